// File: rtl/quant_pkg.sv
// Shared bfloat16 definitions for the quantization stream: field widths,
// exponent bias, rounding-mode encodings and operand classification.
package quant_pkg;

  localparam int BF16_W     = 16;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int BF16_BIAS  = 127;

  localparam logic ROUND_RNE   = 1'b0;
  localparam logic ROUND_TRUNC = 1'b1;

  localparam logic [BF16_W-1:0] BF16_ONE = 16'h3F80;
  localparam logic [BF16_W-1:0] BF16_NAN = 16'h7FC0;

  // Mantissa product with hidden ones; its LSB weighs 2^(ea+eb-EXP_OFFSET).
  localparam int PROD_W     = 2 * (BF16_MAN_W + 1);
  localparam int EXP_OFFSET = 2 * BF16_BIAS + 2 * BF16_MAN_W;
  localparam int EXP_SUM_W  = 11;

  typedef struct packed {
    logic                  sign;
    logic [BF16_EXP_W-1:0] exp;
    logic [BF16_MAN_W-1:0] man;
  } bf16_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } bf16_class_e;

  // Subnormals are flushed, so any zero exponent classifies as zero.
  function automatic bf16_class_e bf16_classify(input bf16_t x);
    if (x.exp == '0)      return CLS_ZERO;
    else if (x.exp != '1) return CLS_NORM;
    else if (x.man == '0) return CLS_INF;
    else                  return CLS_NAN;
  endfunction

endpackage

// File: rtl/bf16_mul_to_int.sv
// Three-stage bfloat16 x bfloat16 -> signed integer datapath: exact product,
// fixed-point alignment with guard/sticky, then round, clamp and register.
module bf16_mul_to_int
  import quant_pkg::*;
#(
  parameter int MAX_W = 16,
  parameter int CH_W  = 2,
  parameter int BW_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [BF16_W-1:0]    fp_value,
  input  logic [BF16_W-1:0]    scale,
  input  logic [BW_W-1:0]      bitwidth,
  input  logic                 round_mode,
  input  logic [CH_W-1:0]      channel,
  output logic                 out_valid,
  output logic [CH_W-1:0]      out_channel,
  output logic [MAX_W-1:0]     result,
  output logic                 result_sat
);

  // Products at or above 2^BIG_EXP LSB weight exceed any 32-bit clamp range.
  localparam int BIG_EXP = 18;
  localparam int MAG_W   = PROD_W + BIG_EXP - 1;
  localparam int RES_W   = MAG_W + 1;
  localparam logic signed [EXP_SUM_W-1:0] EXP_BIG   = EXP_SUM_W'(BIG_EXP);
  localparam logic signed [EXP_SUM_W-1:0] EXP_FLOOR = -EXP_SUM_W'(PROD_W);

  // ---------------- S1: classify, exponent add, mantissa product ----------
  bf16_t       a, b;
  bf16_class_e a_cls, b_cls;
  logic                        s1_kill_d, s1_inf_d;
  logic [PROD_W-1:0]           s1_prod_d;
  logic signed [EXP_SUM_W-1:0] s1_exp_d;
  logic [BW_W-1:0]             s1_bw_d;

  assign a     = bf16_t'(fp_value);
  assign b     = bf16_t'(scale);
  assign a_cls = bf16_classify(a);
  assign b_cls = bf16_classify(b);

  // NaN or any zero operand (including 0 x Inf) yields a plain zero.
  assign s1_kill_d = (a_cls == CLS_NAN) || (b_cls == CLS_NAN) ||
                     (a_cls == CLS_ZERO) || (b_cls == CLS_ZERO);
  assign s1_inf_d  = (a_cls == CLS_INF) || (b_cls == CLS_INF);
  assign s1_prod_d = PROD_W'({1'b1, a.man}) * PROD_W'({1'b1, b.man});
  assign s1_exp_d  = EXP_SUM_W'({3'b000, a.exp}) + EXP_SUM_W'({3'b000, b.exp})
                   - EXP_SUM_W'(EXP_OFFSET);
  assign s1_bw_d   = ((bitwidth < BW_W'(2)) || (bitwidth > BW_W'(MAX_W)))
                   ? BW_W'(MAX_W) : bitwidth;

  logic                        s1_valid, s1_sign, s1_kill, s1_inf, s1_mode;
  logic [PROD_W-1:0]           s1_prod;
  logic signed [EXP_SUM_W-1:0] s1_exp;
  logic [BW_W-1:0]             s1_bw;
  logic [CH_W-1:0]             s1_ch;

  // ---------------- S2: align to integer with guard/sticky ----------------
  logic [MAG_W-1:0]  s2_mag_d;
  logic              s2_guard_d, s2_sticky_d, s2_big_d;
  logic [2*PROD_W-1:0] frac;
  logic [4:0]        rsh;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    s2_mag_d    = '0;
    s2_guard_d  = 1'b0;
    s2_sticky_d = 1'b0;
    s2_big_d    = s1_inf;
    frac        = '0;
    rsh         = '0;
    if (s1_exp >= EXP_BIG) begin
      s2_big_d = 1'b1;
    end else if (!s1_exp[EXP_SUM_W-1]) begin
      s2_mag_d = MAG_W'(s1_prod) << s1_exp[4:0];
    end else if (s1_exp < EXP_FLOOR) begin
      s2_sticky_d = |s1_prod;
    end else begin
      rsh         = 5'(-s1_exp);
      frac        = {s1_prod, {PROD_W{1'b0}}} >> rsh;
      s2_mag_d    = MAG_W'(frac[2*PROD_W-1:PROD_W]);
      s2_guard_d  = frac[PROD_W-1];
      s2_sticky_d = |frac[PROD_W-2:0];
    end
  end

  logic             s2_valid, s2_sign, s2_kill, s2_big, s2_mode;
  logic             s2_guard, s2_sticky;
  logic [MAG_W-1:0] s2_mag;
  logic [BW_W-1:0]  s2_bw;
  logic [CH_W-1:0]  s2_ch;

  // ---------------- S3: round, clamp, sign ---------------------------------
  logic             s3_inc, s3_over;
  logic [RES_W-1:0] mag_r, lim;
  logic [MAX_W-1:0] mag_c, result_d;
  logic             result_sat_d;

  always_comb begin
    s3_inc  = (s2_mode == ROUND_RNE) && s2_guard && (s2_sticky || s2_mag[0]);
    mag_r   = RES_W'(s2_mag) + RES_W'(s3_inc);
    // Negative side reaches one further than the positive side.
    lim     = (RES_W'(1) << (s2_bw - BW_W'(1))) - RES_W'(!s2_sign);
    s3_over = s2_big || (mag_r > lim);
    mag_c   = s3_over ? lim[MAX_W-1:0] : mag_r[MAX_W-1:0];
    result_d     = s2_kill ? '0 : (s2_sign ? -mag_c : mag_c);
    result_sat_d = !s2_kill && s3_over;
  end

  // ---------------- Registers ---------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_valid   <= 1'b0;
      result      <= '0;
      result_sat  <= 1'b0;
      out_channel <= '0;
    end else if (en) begin
      s1_valid    <= in_valid;
      s2_valid    <= s1_valid;
      out_valid   <= s2_valid;
      result      <= result_d;
      result_sat  <= result_sat_d;
      out_channel <= s2_ch;
    end
  end

  // NOTE: payload registers are qualified by their valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_sign   <= a.sign ^ b.sign;
      s1_kill   <= s1_kill_d;
      s1_inf    <= s1_inf_d;
      s1_prod   <= s1_prod_d;
      s1_exp    <= s1_exp_d;
      s1_bw     <= s1_bw_d;
      s1_mode   <= round_mode;
      s1_ch     <= channel;
      s2_sign   <= s1_sign;
      s2_kill   <= s1_kill;
      s2_big    <= s2_big_d;
      s2_mag    <= s2_mag_d;
      s2_guard  <= s2_guard_d;
      s2_sticky <= s2_sticky_d;
      s2_bw     <= s1_bw;
      s2_mode   <= s1_mode;
      s2_ch     <= s1_ch;
    end
  end

endmodule

// File: rtl/quantization_stream.sv
// Streaming bfloat16 quantizer: per-channel scale table, valid/ready
// handshake around the three-stage datapath, and a saturation counter.
module quantization_stream
  import quant_pkg::*;
#(
  parameter int MAX_BITWIDTH_QUANTIZED_DATA = 16,
  parameter int NUM_CHANNELS                = 4,
  parameter int SAT_CNT_WIDTH               = 16,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int BW_W = $clog2(MAX_BITWIDTH_QUANTIZED_DATA) + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   scale_we,
  input  logic [CH_W-1:0]                        scale_waddr,
  input  logic [BF16_W-1:0]                      scale_wdata,
  input  logic [BW_W-1:0]                        bitwidth,
  input  logic                                   round_mode,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [CH_W-1:0]                        in_channel,
  input  logic [BF16_W-1:0]                      fp_value,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [CH_W-1:0]                        out_channel,
  output logic [MAX_BITWIDTH_QUANTIZED_DATA-1:0] result,
  output logic                                   result_sat,
  output logic [SAT_CNT_WIDTH-1:0]               sat_count,
  input  logic                                   sat_clear
);

  localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CHANNELS);

  logic                advance;
  logic [BF16_W-1:0]   scale_tbl [NUM_CHANNELS];
  logic [BF16_W-1:0]   scale_rd;

  // The whole pipeline moves together; ready never looks at in_valid.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    scale_rd = BF16_ONE;
    if ({1'b0, in_channel} < NUM_CH_L) scale_rd = scale_tbl[in_channel];
  end

  // NOTE: the scale table is a small register file with a defined reset value, not a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) scale_tbl[i] <= BF16_ONE;
    end else if (scale_we && ({1'b0, scale_waddr} < NUM_CH_L)) begin
      scale_tbl[scale_waddr] <= scale_wdata;
    end
  end

  bf16_mul_to_int #(
    .MAX_W (MAX_BITWIDTH_QUANTIZED_DATA),
    .CH_W  (CH_W),
    .BW_W  (BW_W)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .en          (advance),
    .in_valid    (in_valid),
    .fp_value    (fp_value),
    .scale       (scale_rd),
    .bitwidth    (bitwidth),
    .round_mode  (round_mode),
    .channel     (in_channel),
    .out_valid   (out_valid),
    .out_channel (out_channel),
    .result      (result),
    .result_sat  (result_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (sat_clear) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && result_sat && (sat_count != '1)) begin
      sat_count <= sat_count + SAT_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_quantization_stream.sv
// Randomized bench for quantization_stream against a real-arithmetic
// reference model, plus directed cases for rounding, clamping and reset.
module tb_quantization_stream;
  import quant_pkg::*;

  localparam int MAXW = 16;
  localparam int NCH  = 4;
  localparam int SCW  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        scale_we;
  logic [1:0]  scale_waddr;
  logic [15:0] scale_wdata;
  logic [4:0]  bitwidth;
  logic        round_mode;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_channel;
  logic [15:0] fp_value;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_channel;
  logic [15:0] result;
  logic        result_sat;
  logic [15:0] sat_count;
  logic        sat_clear;

  quantization_stream #(
    .MAX_BITWIDTH_QUANTIZED_DATA (MAXW),
    .NUM_CHANNELS                (NCH),
    .SAT_CNT_WIDTH               (SCW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scale_we    (scale_we),
    .scale_waddr (scale_waddr),
    .scale_wdata (scale_wdata),
    .bitwidth    (bitwidth),
    .round_mode  (round_mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_channel  (in_channel),
    .fp_value    (fp_value),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel),
    .result      (result),
    .result_sat  (result_sat),
    .sat_count   (sat_count),
    .sat_clear   (sat_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint res;
    bit     sat;
    int     ch;
    int     acc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_scale [NCH];
  int          m_sat;
  int          cyc;
  int          checks;
  int          errors;
  bit          check_lat;
  bit          lit_en;
  longint      lit_res;
  bit          lit_sat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, $signed(got), $signed(want), $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic bit is_nan(input logic [15:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
  endfunction

  function automatic bit is_inf(input logic [15:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] == 7'd0);
  endfunction

  function automatic real bf2r(input logic [15:0] x);
    real m;
    m = (128.0 + real'(int'(x[6:0]))) / 128.0 * pow2(int'(x[14:7]) - 127);
    return x[15] ? -m : m;
  endfunction

  function automatic void model(input logic [15:0] fp, input logic [15:0] sc, input int bw,
                                input bit mode, output longint res, output bit sat);
    int     w;
    longint hi, lo, q, v;
    real    a, fl, fr;
    bit     neg;
    w   = (bw < 2 || bw > MAXW) ? MAXW : bw;
    hi  = (longint'(1) <<< (w - 1)) - 1;
    lo  = -(longint'(1) <<< (w - 1));
    neg = fp[15] ^ sc[15];
    res = 0;
    sat = 1'b0;
    if (is_nan(fp) || is_nan(sc) || fp[14:7] == 8'd0 || sc[14:7] == 8'd0) return;
    if (is_inf(fp) || is_inf(sc)) begin
      res = neg ? lo : hi;
      sat = 1'b1;
      return;
    end
    a = bf2r(fp) * bf2r(sc);
    if (a < 0.0) a = -a;
    if (a >= pow2(40)) begin
      q = longint'(1) <<< 40;
    end else begin
      fl = $floor(a);
      q  = longint'(fl);
      fr = a - fl;
      if (!mode && (fr > 0.5 || (fr == 0.5 && (q % 2) == 1))) q++;
    end
    v = neg ? -q : q;
    if (v > hi) begin
      res = hi;
      sat = 1'b1;
    end else if (v < lo) begin
      res = lo;
      sat = 1'b1;
    end else begin
      res = v;
    end
  endfunction

  function automatic logic [15:0] rnd_bf(input int lo, input int hi);
    logic [15:0] v;
    int r;
    r       = $urandom_range(0, 19);
    v[15]   = 1'($urandom_range(0, 1));
    v[6:0]  = 7'($urandom);
    if (r == 0)      v[14:7] = 8'd0;
    else if (r == 1) v[14:7] = 8'hFF;
    else             v[14:7] = 8'($urandom_range(lo, hi));
    return v;
  endfunction

  // ---------------- one clock cycle: check, account, advance ----------------
  task automatic cycle(output bit acc);
    exp_t   e;
    bit     hs, hs_sat;
    longint r;
    bit     s;
    #1;
    check("in_ready", in_ready, !out_valid || out_ready);
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", out_valid, 1'b0);
      end else begin
        check("result", longint'($signed(result)), sb[0].res);
        check("result_sat", result_sat, sb[0].sat);
        check("out_channel", out_channel, sb[0].ch);
      end
    end
    hs     = out_valid && out_ready && (sb.size() != 0);
    hs_sat = 1'b0;
    acc    = in_valid && in_ready;
    if (acc) begin
      if (lit_en) begin
        e.res = lit_res;
        e.sat = lit_sat;
      end else begin
        model(fp_value, m_scale[in_channel], int'(bitwidth), round_mode, r, s);
        e.res = r;
        e.sat = s;
      end
      e.ch  = int'(in_channel);
      e.acc = cyc + 1;
    end
    @(posedge clk);
    cyc++;
    if (hs) begin
      if (check_lat) check("latency", cyc - sb[0].acc, 3);
      hs_sat = sb[0].sat;
      void'(sb.pop_front());
    end
    if (acc) sb.push_back(e);
    if (sat_clear) m_sat = 0;
    else if (hs_sat && m_sat < (1 << SCW) - 1) m_sat++;
    if (scale_we) m_scale[scale_waddr] = scale_wdata;
    #1;
    check("sat_count", sat_count, m_sat);
  endtask

  task automatic set_idle();
    in_valid  = 1'b0;
    scale_we  = 1'b0;
    sat_clear = 1'b0;
    out_ready = 1'b1;
    lit_en    = 1'b0;
  endtask

  task automatic send_lit(input logic [15:0] fp, input int ch, input int bw, input bit mode,
                          input longint res, input bit sat);
    bit a = 1'b0;
    fp_value   = fp;
    in_channel = 2'(ch);
    bitwidth   = 5'(bw);
    round_mode = mode;
    in_valid   = 1'b1;
    lit_en     = 1'b1;
    lit_res    = res;
    lit_sat    = sat;
    for (int i = 0; i < 20 && !a; i++) cycle(a);
    check("accept_timeout", a, 1'b1);
    in_valid = 1'b0;
    lit_en   = 1'b0;
  endtask

  task automatic drain();
    bit a;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && sb.size() != 0; i++) cycle(a);
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic rand_sample(input int bw_lo, input int bw_hi);
    fp_value   = rnd_bf(105, 150);
    in_channel = 2'($urandom_range(0, NCH - 1));
    bitwidth   = 5'($urandom_range(bw_lo, bw_hi));
    round_mode = 1'($urandom_range(0, 1));
  endtask

  initial begin
    bit a;
    int idx;
    rst = 1'b1;
    set_idle();
    scale_waddr = '0;
    scale_wdata = '0;
    bitwidth    = 5'd8;
    round_mode  = 1'b0;
    in_channel  = '0;
    fp_value    = '0;
    for (int i = 0; i < NCH; i++) m_scale[i] = BF16_ONE;
    m_sat = 0;
    cyc   = 0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 16'd0);
    check("rst_result_sat", result_sat, 1'b0);
    check("rst_out_channel", out_channel, 2'd0);
    check("rst_sat_count", sat_count, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1.5 x 2.0 -> 3, three-cycle latency
    scale_we    = 1'b1;
    scale_waddr = 2'd0;
    scale_wdata = 16'h4000;
    cycle(a);
    scale_we  = 1'b0;
    check_lat = 1'b1;
    send_lit(16'h3FC0, 0, 8, 1'b0, 3, 1'b0);
    drain();
    check_lat = 1'b0;

    // rounding modes on ties, scale left at its reset value of 1.0
    send_lit(16'h4020, 1, 8, 1'b0, 2, 1'b0);
    send_lit(16'h4060, 1, 8, 1'b0, 4, 1'b0);
    send_lit(16'hBFC0, 1, 8, 1'b0, -2, 1'b0);
    send_lit(16'h4020, 1, 8, 1'b1, 2, 1'b0);
    send_lit(16'h4060, 1, 8, 1'b1, 3, 1'b0);
    send_lit(16'hBFC0, 1, 8, 1'b1, -1, 1'b0);
    drain();

    // clamping and NaN
    send_lit(16'h4348, 1, 8, 1'b0, 127, 1'b1);
    send_lit(16'hC396, 1, 8, 1'b0, -128, 1'b1);
    send_lit(BF16_NAN, 1, 8, 1'b0, 0, 1'b0);
    drain();
    check("sat_count_clamp", sat_count, 16'd2);

    // 16 back-to-back samples against a 1-0-0-1 consumer
    idx = 0;
    rand_sample(0, 31);
    for (int k = 0; k < 200 && idx < 16; k++) begin
      in_valid  = 1'b1;
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      cycle(a);
      if (a) begin
        idx++;
        rand_sample(0, 31);
      end
    end
    check("burst_accepted", idx, 16);
    drain();

    // same-cycle scale write sees the old scale
    scale_we    = 1'b1;
    scale_waddr = 2'd2;
    scale_wdata = 16'h4000;
    in_valid    = 1'b1;
    in_channel  = 2'd2;
    fp_value    = 16'h3F80;
    bitwidth    = 5'd8;
    round_mode  = 1'b0;
    lit_en      = 1'b1;
    lit_res     = 1;
    lit_sat     = 1'b0;
    cycle(a);
    check("accept_same_cycle_write", a, 1'b1);
    scale_we = 1'b0;
    lit_res  = 2;
    cycle(a);
    check("accept_after_write", a, 1'b1);
    lit_en = 1'b0;
    drain();

    // random traffic with stalls, scale writes and occasional clears
    rand_sample(0, 31);
    for (int k = 0; k < 400; k++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 9) < 7);
      scale_we    = ($urandom_range(0, 9) == 0);
      scale_waddr = 2'($urandom_range(0, NCH - 1));
      scale_wdata = rnd_bf(118, 136);
      sat_clear   = ($urandom_range(0, 29) == 0);
      cycle(a);
      if (a || !in_valid) rand_sample(0, 31);
    end
    scale_we  = 1'b0;
    sat_clear = 1'b0;
    drain();

    // saturation-heavy traffic, then reset in the middle of it
    scale_we    = 1'b1;
    scale_waddr = 2'd2;
    scale_wdata = 16'h4000;
    cycle(a);
    scale_we = 1'b0;
    rand_sample(2, 6);
    for (int k = 0; k < 30; k++) begin
      in_valid  = 1'b1;
      out_ready = ($urandom_range(0, 4) != 0);
      cycle(a);
      if (a) rand_sample(2, 6);
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_result", result, 16'd0);
    check("midrst_result_sat", result_sat, 1'b0);
    check("midrst_sat_count", sat_count, 16'd0);
    sb.delete();
    m_sat = 0;
    for (int i = 0; i < NCH; i++) m_scale[i] = BF16_ONE;
    set_idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send_lit(16'h3F80, 2, 8, 1'b0, 1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quantization_stream.md
QUANTIZATION_STREAM -- requirements
Module: quantization_stream

Interface
REQ-001 Parameter MAX_BITWIDTH_QUANTIZED_DATA, default 16, SHALL set max output integer width (range 4..32).
REQ-002 Parameter NUM_CHANNELS, default 4, SHALL set the number of per-channel scale registers (CH_W = max(1,$clog2(NUM_CHANNELS))).
REQ-003 Parameter SAT_CNT_WIDTH, default 16, SHALL set the saturation event counter width.
REQ-004 Ports SHALL be:
clk  in  1  single clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-high
scale_we  in  1  scale table write strobe
scale_waddr  in  CH_W  channel written
scale_wdata  in  16  bfloat16 scale
bitwidth  in  $clog2(MAX)+1  target signed width, sampled per accepted sample
round_mode  in  1  0 = round-half-even, 1 = truncate toward zero; sampled per sample
in_valid  in  1  input sample valid
in_ready  out  1  block accepts sample this cycle
in_channel  in  CH_W  channel of sample, selects scale
fp_value  in  16  bfloat16 sample
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_channel  out  CH_W  channel carried with result
result  out  MAX  signed integer, sign-extended from bitwidth
result_sat  out  1  result was clamped or input was Inf
sat_count  out  SAT_CNT_WIDTH  saturating count of handshaked results with result_sat=1
sat_clear  in  1  synchronous clear of sat_count

Function
REQ-005 Accepted sample (in_valid & in_ready) SHALL produce result = clamp(Q(fp_value * scale[in_channel])) with exact product (8x8-bit mantissa, no intermediate rounding).
REQ-006 Q SHALL be round-half-even when round_mode=0, truncation toward zero when round_mode=1.
REQ-007 Clamp range SHALL be [-(2^(bitwidth-1)), 2^(bitwidth-1)-1]; result_sat=1 iff clamping changed the value.
REQ-008 bitwidth outside 2..MAX SHALL be treated as MAX.
REQ-009 Subnormal operands SHALL flush to zero; NaN operand SHALL give result 0, result_sat=0; Inf (non-NaN) SHALL give min/max by sign, result_sat=1; 0*Inf SHALL give 0.
REQ-010 Pipeline SHALL be 3 stages: S1 sign/exponent add + mantissa product; S2 align to fixed point with guard/sticky; S3 round, clamp, register outputs.
REQ-011 Latency SHALL be 3 cycles from acceptance to out_valid with out_ready held high; throughput 1 sample/cycle.
REQ-012 Stall: advance = !out_valid | out_ready; in_ready = advance; whole pipeline holds when advance=0; no sample dropped or duplicated.
REQ-013 result, result_sat, out_channel SHALL stay stable while out_valid & !out_ready.
REQ-014 in_ready SHALL not depend combinationally on in_valid.
REQ-015 Scale SHALL be read at acceptance; write to same channel in same cycle SHALL give the old scale to that sample, new scale from next cycle.
REQ-016 bitwidth, round_mode, channel SHALL travel with the sample; changing them mid-flight SHALL not affect in-flight samples.
REQ-017 sat_count SHALL increment on out_valid & out_ready & result_sat, saturate at all-ones; sat_clear wins over simultaneous increment.

Reset
REQ-018 rst SHALL asynchronously clear all stage valids, out_valid=0, result=0, result_sat=0, out_channel=0, sat_count=0.
REQ-019 Scale registers SHALL reset to 0x3F80 (1.0).
REQ-020 rst mid-operation SHALL discard in-flight samples; in_ready=1 in the first cycle after release.

Structure
REQ-021 Shared package quant_pkg SHALL hold bfloat16 field widths, exponent bias 127, ROUND_RNE/ROUND_TRUNC constants, and canonical 1.0/NaN encodings.
REQ-022 One sub-module bf16_mul_to_int (stages S1-S3 datapath with enable) SHALL be instantiated; scale table, handshake and counter stay in top.

Verification
REQ-023 0x3FC0 (1.5) x scale 0x4000 (2.0), bitwidth 8, mode 0 -> result 3, sat 0, out_valid exactly 3 cycles after accept.
REQ-024 0x4020 (2.5), 0x4060 (3.5), 0xBFC0 (-1.5) x 1.0, mode 0 -> 2, 4, -2; mode 1 -> 2, 3, -1.
REQ-025 bitwidth 8: 0x4348 (200.0) -> 127 sat=1; 0xC396 (-300.0) -> -128 sat=1; 0x7FC0 (NaN) -> 0 sat=0; sat_count=2.
REQ-026 Back-to-back 16 samples, out_ready toggling 1-0-0-1 pattern -> all 16 results in order, values held stable during stalls, in_ready low only when out_valid & !out_ready.
REQ-027 Write channel 2 scale 0x4000 in same cycle as channel-2 sample 0x3F80 -> result 1; next-cycle sample -> 2; assert rst mid-stream -> out_valid=0, sat_count=0, scale back to 1.0.
